buf_512w_rd_streamer: RTL and testbench
=======================================

Name: buf_512w_rd_streamer

Overview:
- Read-side engine for the 512-bit x 65536-deep simple dual-port staging buffer. It is the consumer counterpart to the write path that loads the buffer.
- Accepts a (start address, length) command and drives the buffer's read address, one entry per cycle.
- Tracks the fixed RAM read latency and presents the returned entries as a valid/ready stream with a last marker.
- Backpressure is absorbed by an internal skid FIFO with credit-based issue, so no RAM read is ever lost.

Parameters:
- DATA_W, 512, buffer entry width.
- ADDR_W, 16, buffer address width (depth 2^ADDR_W).
- RD_LAT, 2, clock cycles from rdaddress to valid q; must be 1..4.
- SKID_DEPTH, 8, output FIFO entries; must be >= RD_LAT+2 and a power of 2.

Ports:
- clock  in  1  single clock for the block and the buffer.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  ADDR_W  first buffer address.
- cmd_len  in  ADDR_W+1  number of entries, 0..65536.
- rdaddress  out  ADDR_W  to buffer read address.
- q  in  DATA_W  buffer read data.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  sink accept.
- out_data  out  DATA_W  entry data.
- out_last  out  1  final beat of the command.
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle pulse when the last beat is accepted (or for a zero-length command).

Behaviour:
- Reset values: cmd_ready=0 while reset_n low, then 1; rdaddress=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0. The FIFO, latency pipeline, counters and FSM all clear immediately.
- Reset mid-command: the command is abandoned, no done pulse, in-flight reads are discarded.
- FSM states:
  - IDLE: on cmd_valid&&cmd_ready, latch addr and len. If len==0, go to IDLE and pulse done next cycle. Otherwise go to ISSUE.
  - ISSUE: each cycle, if credit is available, present rdaddress=cur_addr, push a valid token into the RD_LAT-deep shift pipeline, increment cur_addr and decrement the issue count. On the final issue, go to DRAIN.
  - DRAIN: wait until the pipeline is empty and the FIFO is empty with the last beat accepted, then go to IDLE with done=1 for one cycle.
- Credit rule: issue only when (tokens in pipeline + FIFO occupancy) < SKID_DEPTH. Evaluate using registered counts; a pop in the same cycle does not add credit until the next cycle. The FIFO therefore never overflows.
- Read latency: a token issued at cycle t writes q into the FIFO at cycle t+RD_LAT. Each token carries a last flag set for the final issued address.
- Throughput: with out_ready held high, first out_valid occurs RD_LAT+1 cycles after command accept. After that, one beat per cycle with no bubbles.
- Address arithmetic: cur_addr increments modulo 2^ADDR_W. Start 0xFFFF with len 3 reads 0xFFFF, 0x0000, 0x0001. len 65536 reads every entry exactly once.
- Output: out_data, out_valid and out_last come from the FIFO head, registered. A beat transfers on out_valid&&out_ready. out_valid must not drop and out_data must not change while out_valid&&!out_ready.
- Simultaneous FIFO push and pop: allowed in the same cycle, occupancy unchanged.
- A command presented while busy is not accepted (cmd_ready=0). cmd_* may change freely while not accepted.
- rdaddress holds its last value when not issuing. Reads from the RAM are side-effect free.

Decomposition:
- Shared package buf_rd_pkg: ADDR_W, DATA_W, and the token struct {valid, last}.
- One natural sub-module: buf_rd_skid_fifo, a synchronous FIFO of DATA_W+1 bits by SKID_DEPTH. It provides push, pop, occupancy count, full and empty, and uses the same clock and reset_n.
- The FSM, credit logic and latency pipeline live in the top level.

Test Plan:
- Preload RAM[i]=i; cmd addr=0x0010, len=4, out_ready=1 → beats 0x10, 0x11, 0x12, 0x13 on consecutive cycles. First beat arrives 3 cycles after accept (RD_LAT=2). out_last on the 4th beat, done 1 cycle later.
- Wrap: addr=0xFFFE, len=4 → rdaddress sequence FFFE, FFFF, 0000, 0001, and data matches.
- Backpressure: len=32, out_ready toggled randomly, including 20-cycle stalls → all 32 beats arrive in order with no loss or duplication. FIFO occupancy never exceeds 8 and data stays stable during stalls.
- Zero-length: len=0 → no rdaddress activity, no out_valid, done pulses once, and cmd_ready returns the next cycle.
- Reset mid-stream: len=100, assert reset_n low after 40 beats → outputs clear asynchronously and no done pulse. A new command addr=0, len=2 then completes normally.
- Full-depth: len=65536 from addr=0x8000, out_ready=1 → 65536 beats, last beat carries RAM[0x7FFF], done asserts exactly once.

Source files
------------

// File: rtl/buf_rd_pkg.sv
// Shared definitions for the staging-buffer read streamer.
package buf_rd_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 512;

    // One slot of the read-latency pipeline: a RAM read is in flight.
    typedef struct packed {
        logic valid;
        logic last;
    } token_t;
endpackage

// File: rtl/buf_rd_skid_fifo.sv
// Synchronous FIFO that absorbs RAM returns while the sink stalls.
module buf_rd_skid_fifo
#(
    parameter int W     = 513,
    parameter int DEPTH = 8
)
(
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    import buf_rd_pkg::*;

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/buf_512w_rd_streamer.sv
// Read engine: walks a (start, length) range of the staging buffer and
// streams the returned entries out with credit-based backpressure.
module buf_512w_rd_streamer
#(
    parameter int DATA_W     = buf_rd_pkg::DATA_W,
    parameter int ADDR_W     = buf_rd_pkg::ADDR_W,
    parameter int RD_LAT     = 2,
    parameter int SKID_DEPTH = 8
)
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_len,
    output logic [ADDR_W-1:0] rdaddress,
    input  logic [DATA_W-1:0] q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    import buf_rd_pkg::*;

    localparam int CNT_W = $clog2(SKID_DEPTH) + 1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W:0]   remaining;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  fifo_count;
    token_t            tok_pipe [RD_LAT];
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W:0]   head;
    logic              accept;
    logic              credit;
    logic              issue;
    logic              final_issue;
    logic              push;
    logic              pop;

    assign accept      = cmd_valid && cmd_ready;
    // Registered counts only: a pop this cycle frees a slot next cycle.
    assign credit      = (({1'b0, inflight} + {1'b0, fifo_count}) < (CNT_W+1)'(SKID_DEPTH)) && !fifo_full;
    assign issue       = (state == S_ISSUE) && credit;
    assign final_issue = (remaining == (ADDR_W+1)'(1));
    assign push        = tok_pipe[RD_LAT-1].valid;
    assign pop         = out_valid && out_ready;

    // The RAM registers the address itself, so the issuing address goes out
    // combinationally; otherwise the last issued address is held.
    assign rdaddress   = issue ? cur_addr : last_addr;
    assign cmd_ready   = reset_n && (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign out_valid   = !fifo_empty;
    assign {out_last, out_data} = head;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cur_addr  <= '0;
            last_addr <= '0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cur_addr  <= cmd_addr;
                        remaining <= cmd_len;
                        if (cmd_len == '0) done  <= 1'b1;
                        else               state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue) begin
                        last_addr <= cur_addr;
                        cur_addr  <= cur_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (final_issue) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The last-flagged beat is the final entry, so its
                    // acceptance implies pipeline and FIFO are both empty.
                    if (pop && out_last) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LAT; i++) tok_pipe[i] <= '0;
            inflight <= '0;
        end else begin
            tok_pipe[0].valid <= issue;
            tok_pipe[0].last  <= issue && final_issue;
            for (int i = 1; i < RD_LAT; i++) tok_pipe[i] <= tok_pipe[i-1];
            case ({issue, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    buf_rd_skid_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (SKID_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({tok_pipe[RD_LAT-1].last, q}),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
endmodule

// File: tb/tb_buf_512w_rd_streamer.sv
// Directed bench for the buffer read streamer with a latency-2 RAM model.
module tb_buf_512w_rd_streamer;
    localparam int DATA_W = 512;
    localparam int ADDR_W = 16;
    localparam int RD_LAT = 2;
    localparam int SKID   = 8;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W:0]   cmd_len;
    logic [ADDR_W-1:0] rdaddress;
    logic [DATA_W-1:0] q;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] addr;
        logic [16:0] len;
        bit          stall;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
        int          exp_lat;
    } vec_t;

    vec_t vecs [6];

    always #5 clock = ~clock;

    buf_512w_rd_streamer #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .RD_LAT     (RD_LAT),
        .SKID_DEPTH (SKID)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .rdaddress (rdaddress),
        .q         (q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    // RAM model: every word holds its own address replicated across the entry.
    function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
        return {32{a}};
    endfunction

    logic [ADDR_W-1:0] ram_p [RD_LAT];
    always @(posedge clock) begin
        ram_p[0] <= rdaddress;
        for (int i = 1; i < RD_LAT; i++) ram_p[i] <= ram_p[i-1];
    end
    assign q = ram_word(ram_p[RD_LAT-1]);

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [15:0] a, input logic [16:0] l);
        int n;
        n = 0;
        @(negedge clock);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("cmd_accept", longint'(cmd_ready), 1);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = 16'($urandom);
        cmd_len   = 17'($urandom);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int beats, first_lat, last_k, done_k, done_cnt, budget, stall;
        int data_err, last_err, stab_err, occ_err;
        logic [15:0]       first_d, last_d;
        logic [DATA_W-1:0] exp_d, prev_data;
        bit                prev_stall;
        beats = 0; first_lat = -1; last_k = -1; done_k = -1; done_cnt = 0; stall = 0;
        data_err = 0; last_err = 0; stab_err = 0; occ_err = 0;
        first_d = '0; last_d = '0; prev_data = '0; prev_stall = 0;
        budget = v.stall ? int'(v.len) * 30 + 200 : int'(v.len) + 30;
        if (!v.stall) out_ready = 1'b1;
        send_cmd(v.addr, v.len);
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (!v.stall) out_ready = 1'b1;
            else begin
                if (k == 8 || k == 50) stall = 20;
                if (stall > 0) begin
                    out_ready = 1'b0;
                    stall--;
                end else out_ready = 1'($urandom_range(0, 1));
            end
            if (prev_stall && (!out_valid || out_data !== prev_data)) stab_err++;
            if (dut.u_fifo.count > SKID) occ_err++;
            if (done) begin
                done_cnt++;
                done_k = k;
            end
            if (out_valid && first_lat < 0) first_lat = k;
            if (out_valid && out_ready) begin
                exp_d = ram_word(v.addr + beats[15:0]);
                if (out_data !== exp_d) data_err++;
                if (out_last !== (beats == int'(v.len) - 1)) last_err++;
                if (beats == 0) first_d = out_data[15:0];
                last_d = out_data[15:0];
                last_k = k;
                beats++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (done_k >= 0 && k >= done_k + 3) break;
        end
        check($sformatf("v%0d beats", idx), beats, longint'(v.len));
        check($sformatf("v%0d first_data", idx), first_d, v.exp_first);
        check($sformatf("v%0d last_data", idx), last_d, v.exp_last);
        check($sformatf("v%0d data_errs", idx), data_err, 0);
        check($sformatf("v%0d last_flag_errs", idx), last_err, 0);
        check($sformatf("v%0d done_pulses", idx), done_cnt, 1);
        check($sformatf("v%0d done_gap", idx), done_k - last_k, 1);
        check($sformatf("v%0d first_latency", idx), first_lat, v.exp_lat);
        check($sformatf("v%0d stall_stability_errs", idx), stab_err, 0);
        check($sformatf("v%0d occupancy_errs", idx), occ_err, 0);
        if (!v.stall) check($sformatf("v%0d beat_span", idx), last_k - first_lat, longint'(v.len) - 1);
        check($sformatf("v%0d idle_after", idx), longint'(cmd_ready), 1);
    endtask

    initial begin
        int beats, n, dcnt, vcnt;
        logic [15:0] wrap_exp [5];
        vecs[0] = '{16'h0010, 17'd4,       1'b0, 16'h0010, 16'h0013, 3};
        vecs[1] = '{16'hFFFE, 17'd4,       1'b0, 16'hFFFE, 16'h0001, 3};
        vecs[2] = '{16'h0100, 17'd32,      1'b1, 16'h0100, 16'h011F, 3};
        vecs[3] = '{16'h1234, 17'd1,       1'b0, 16'h1234, 16'h1234, 3};
        vecs[4] = '{16'hFFFF, 17'd3,       1'b0, 16'hFFFF, 16'h0001, 3};
        vecs[5] = '{16'h8000, 17'h10000,   1'b0, 16'h8000, 16'h7FFF, 3};
        wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0001};

        reset_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("rst cmd_ready", longint'(cmd_ready), 0);
        check("rst busy", longint'(busy), 0);
        check("rst out_valid", longint'(out_valid), 0);
        check("rst rdaddress", longint'(rdaddress), 0);
        check("rst done", longint'(done), 0);
        check("rst out_data", longint'(out_data[63:0]), 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst cmd_ready", longint'(cmd_ready), 1);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Wrap: explicit rdaddress sequence, hold, and a command refused while busy.
        out_ready = 1'b1;
        send_cmd(16'hFFFE, 17'd4);
        dcnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check($sformatf("wrap rdaddress k%0d", k), longint'(rdaddress), longint'(wrap_exp[k]));
            if (done) dcnt++;
            if (k == 1) begin
                cmd_valid = 1'b1;
                cmd_len   = '0;
                check("busy cmd_ready", longint'(cmd_ready), 0);
            end else cmd_valid = 1'b0;
        end
        n = 0;
        while (busy && n < 50) begin
            @(negedge clock);
            if (done) dcnt++;
            n++;
        end
        @(negedge clock);
        if (done) dcnt++;
        check("wrap drained", longint'(busy), 0);
        check("wrap done_pulses", dcnt, 1);

        // Zero length: done next cycle, no read, no beat, address held.
        send_cmd(16'h4444, 17'd0);
        @(negedge clock);
        check("zlen done", longint'(done), 1);
        check("zlen cmd_ready", longint'(cmd_ready), 1);
        check("zlen rdaddress", longint'(rdaddress), 16'h0001);
        vcnt = 0; dcnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (out_valid) vcnt++;
            if (done) dcnt++;
        end
        check("zlen out_valid", vcnt, 0);
        check("zlen extra_done", dcnt, 0);

        // Reset in the middle of a long command.
        send_cmd(16'h0200, 17'd100);
        beats = 0; n = 0;
        while (beats < 40 && n < 300) begin
            @(negedge clock);
            out_ready = 1'b1;
            if (out_valid) beats++;
            n++;
        end
        check("midrst beats_before", beats, 40);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrst out_valid", longint'(out_valid), 0);
        check("midrst out_last", longint'(out_last), 0);
        check("midrst out_data", longint'(out_data[63:0]), 0);
        check("midrst busy", longint'(busy), 0);
        check("midrst cmd_ready", longint'(cmd_ready), 0);
        check("midrst rdaddress", longint'(rdaddress), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        vcnt = 0; dcnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (out_valid) vcnt++;
            if (done) dcnt++;
        end
        check("midrst no_done", dcnt, 0);
        check("midrst no_stale_beats", vcnt, 0);
        run_vec('{16'h0000, 17'd2, 1'b0, 16'h0000, 16'h0001, 3}, 10);

        run_vec(vecs[5], 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
